// File: rtl/output_wrapper.sv
// output_wrapper: registered display/LED output stage.
// Decodes four BCD digits to active-low seven-segment codes with optional
// leading-zero blanking and whole-display blinking, stretches single-cycle
// event strobes onto a green LED, and mirrors mode/status onto LEDs.
// Every output is a flop; there is no combinational input-to-output path.

// One display digit: decode plus the output register for that digit.
module segLane (
  input  logic       clkIn,
  input  logic       resetIn,
  input  logic [3:0] digitIn,
  input  logic       blankIn,
  output logic [6:0] hexOut
);

  logic [6:0] segNext;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  always_comb begin
    segNext = 7'h7F;
    if (!blankIn) begin
      case (digitIn)
        4'd0:    segNext = 7'h40;
        4'd1:    segNext = 7'h79;
        4'd2:    segNext = 7'h24;
        4'd3:    segNext = 7'h30;
        4'd4:    segNext = 7'h19;
        4'd5:    segNext = 7'h12;
        4'd6:    segNext = 7'h02;
        4'd7:    segNext = 7'h78;
        4'd8:    segNext = 7'h00;
        4'd9:    segNext = 7'h10;
        default: segNext = 7'h3F;
      endcase
    end
  end

  // Output register; reset shows all segments off.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) hexOut <= 7'h7F;
    else         hexOut <= segNext;
  end

endmodule

module output_wrapper #(
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter int PULSE_STRETCH     = 5000000
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [15:0] digitsIn,
  input  logic        blankLeadingIn,
  input  logic        blinkEnIn,
  input  logic        demoOrRealModeIn,
  input  logic        eventPulseIn,
  input  logic [3:0]  statusIn,
  output logic [6:0]  hex0Out,
  output logic [6:0]  hex1Out,
  output logic [6:0]  hex2Out,
  output logic [6:0]  hex3Out,
  output logic [1:0]  ledGreenOut,
  output logic [3:0]  ledRedOut
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;
  localparam int BW        = $clog2(BLINK_HALF_PERIOD);
  localparam int SW        = $clog2(PULSE_STRETCH + 1);
  localparam logic [BW-1:0] BLINK_TC     = BW'(BLINK_HALF_PERIOD - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(PULSE_STRETCH);

  logic [NUM_LANES-1:0][VEC_W-1:0] digits;
  logic [NUM_LANES-1:0][6:0]       hexArr;
  logic [NUM_LANES-1:0]            laneBlank;
  // zeroAbove[i]: digit i and every digit to its left are zero.
  logic [NUM_LANES:0]              zeroAbove;

  logic [BW-1:0] blinkCnt;
  logic          blinkPhase;
  logic          blinkOff;
  logic [SW-1:0] stretchCnt;
  logic [SW-1:0] stretchNext;

  assign digits               = digitsIn;
  assign zeroAbove[NUM_LANES] = 1'b1;
  assign blinkOff             = blinkEnIn & blinkPhase;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : gLane
      assign zeroAbove[i] = zeroAbove[i+1] && (digits[i] == '0);
      // The rightmost digit always shows, even when the value is zero.
      if (i == 0) begin : gRight
        assign laneBlank[i] = blinkOff;
      end else begin : gLead
        assign laneBlank[i] = blinkOff | (blankLeadingIn & zeroAbove[i]);
      end
      segLane uLane (
        .clkIn   (clkIn),
        .resetIn (resetIn),
        .digitIn (digits[i]),
        .blankIn (laneBlank[i]),
        .hexOut  (hexArr[i])
      );
    end
  endgenerate

  assign hex0Out = hexArr[0];
  assign hex1Out = hexArr[1];
  assign hex2Out = hexArr[2];
  assign hex3Out = hexArr[3];

  // Blink timebase; held at zero while disabled so a blink starts visible.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (!blinkEnIn) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (blinkCnt == BLINK_TC) begin
      blinkCnt   <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCnt   <= blinkCnt + 1'b1;
    end
  end

  // Stretcher next value: a strobe (re)loads the full count, else count down.
  always_comb begin
    stretchNext = stretchCnt;
    if (eventPulseIn)           stretchNext = STRETCH_LOAD;
    else if (stretchCnt != '0)  stretchNext = stretchCnt - 1'b1;
  end

  // Stretch counter and LED registers; the event LED uses the next count
  // so it lights on the same edge that samples the strobe.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      stretchCnt  <= '0;
      ledGreenOut <= '0;
      ledRedOut   <= '0;
    end else begin
      stretchCnt  <= stretchNext;
      ledGreenOut <= {stretchNext != '0, demoOrRealModeIn};
      ledRedOut   <= statusIn;
    end
  end

endmodule

// File: tb/tb_output_wrapper.sv
// tb_output_wrapper: directed stimulus, a behavioural model checked on every
// falling edge, and literal expectations that pin the model.
module tb_output_wrapper;

  localparam int BH = 4;
  localparam int PS = 3;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b0;
  logic [15:0] digitsIn = '0;
  logic        blankLeadingIn = 1'b0;
  logic        blinkEnIn = 1'b0;
  logic        demoOrRealModeIn = 1'b0;
  logic        eventPulseIn = 1'b0;
  logic [3:0]  statusIn = '0;
  logic [6:0]  hex0Out, hex1Out, hex2Out, hex3Out;
  logic [1:0]  ledGreenOut;
  logic [3:0]  ledRedOut;

  output_wrapper #(.BLINK_HALF_PERIOD(BH), .PULSE_STRETCH(PS)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .digitsIn(digitsIn),
    .blankLeadingIn(blankLeadingIn), .blinkEnIn(blinkEnIn),
    .demoOrRealModeIn(demoOrRealModeIn), .eventPulseIn(eventPulseIn),
    .statusIn(statusIn), .hex0Out(hex0Out), .hex1Out(hex1Out),
    .hex2Out(hex2Out), .hex3Out(hex3Out), .ledGreenOut(ledGreenOut),
    .ledRedOut(ledRedOut)
  );

  always #5 clkIn = ~clkIn;

  int nCmp = 0;
  int nBad = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                              7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [6:0] expHex [4];
  logic [1:0] expGreen;
  logic [3:0] expRed;
  int  edgeNo = 0;
  int  lastPulse = -1000000;
  int  blinkEdges = 0;      // edges seen since blinking was enabled
  bit  blankAll;
  bit  allZeroLeft;

  always @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      for (int i = 0; i < 4; i++) expHex[i] = 7'h7F;
      expGreen   = '0;
      expRed     = '0;
      blinkEdges = 0;
      lastPulse  = -1000000;
    end else begin
      edgeNo++;
      blankAll = 1'b0;
      if (blinkEnIn) begin
        blankAll = ((blinkEdges / BH) % 2) == 1;
        blinkEdges++;
      end else begin
        blinkEdges = 0;
      end
      for (int i = 0; i < 4; i++) begin
        allZeroLeft = 1'b1;
        for (int j = i; j < 4; j++)
          if (digitsIn[4*j +: 4] != 4'd0) allZeroLeft = 1'b0;
        if (blankAll)                                expHex[i] = 7'h7F;
        else if (blankLeadingIn && i > 0 && allZeroLeft) expHex[i] = 7'h7F;
        else                                         expHex[i] = segTab[digitsIn[4*i +: 4]];
      end
      if (eventPulseIn) lastPulse = edgeNo;
      expGreen = {(edgeNo - lastPulse) < PS, demoOrRealModeIn};
      expRed   = statusIn;
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clkIn) begin
    if (checkEn) begin
      chk("cmp_hex0", hex0Out, expHex[0]);
      chk("cmp_hex1", hex1Out, expHex[1]);
      chk("cmp_hex2", hex2Out, expHex[2]);
      chk("cmp_hex3", hex3Out, expHex[3]);
      chk("cmp_green", ledGreenOut, expGreen);
      chk("cmp_red", ledRedOut, expRed);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clkIn);
    #2;
  endtask

  int cnt;
  logic [6:0] sweepExp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                7'h3F, 7'h3F, 7'h3F, 7'h3F};

  initial begin
    // Asynchronous reset with no clock edge yet.
    #1 resetIn = 1'b1;
    #1;
    chk("rst_hex0", hex0Out, 7'h7F);
    chk("rst_hex3", hex3Out, 7'h7F);
    chk("rst_green", ledGreenOut, 0);
    chk("rst_red", ledRedOut, 0);
    checkEn = 1'b1;
    tick();
    resetIn = 1'b0;
    digitsIn = 16'h1234;
    tick();
    chk("h1234_hex3", hex3Out, 7'h79);
    chk("h1234_hex2", hex2Out, 7'h24);
    chk("h1234_hex1", hex1Out, 7'h30);
    chk("h1234_hex0", hex0Out, 7'h19);

    // Decode sweep on digit0, blanking off.
    for (int d = 0; d < 16; d++) begin
      digitsIn = {12'h000, 4'(d)};
      tick();
      chk("sweep_hex0", hex0Out, sweepExp[d]);
    end

    // Leading-zero blanking.
    blankLeadingIn = 1'b1;
    digitsIn = 16'h0045;
    tick();
    chk("blz45_hex3", hex3Out, 7'h7F);
    chk("blz45_hex2", hex2Out, 7'h7F);
    chk("blz45_hex1", hex1Out, 7'h19);
    chk("blz45_hex0", hex0Out, 7'h12);
    digitsIn = 16'h0000;
    tick();
    chk("blz0_hex1", hex1Out, 7'h7F);
    chk("blz0_hex0", hex0Out, 7'h40);
    digitsIn = 16'h0A05;
    tick();
    chk("blzA_hex3", hex3Out, 7'h7F);
    chk("blzA_hex2", hex2Out, 7'h3F);
    chk("blzA_hex1", hex1Out, 7'h40);
    chk("blzA_hex0", hex0Out, 7'h12);
    blankLeadingIn = 1'b0;

    // Blink: 4 visible, 4 blank, repeating.
    digitsIn = 16'h8888;
    blinkEnIn = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      chk("blink_hex0", hex0Out, (((t - 1) / 4) % 2) == 1 ? 7'h7F : 7'h00);
    end
    chk("blink_hex3", hex3Out, 7'h7F);
    blinkEnIn = 1'b0;            // dropped during a blank phase
    tick();
    chk("blink_drop", hex0Out, 7'h00);
    blinkEnIn = 1'b1;            // restart with a visible phase
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("blink_re", hex2Out, t == 5 ? 7'h7F : 7'h00);
    end
    blinkEnIn = 1'b0;
    tick();

    // Stretch: single pulse.
    eventPulseIn = 1'b1;
    tick();
    eventPulseIn = 1'b0;
    cnt = (ledGreenOut[1] === 1'b1) ? 1 : 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (ledGreenOut[1] === 1'b1) cnt++;
    end
    chk("stretch_len", cnt, 3);

    // Retrigger two cycles after the first pulse.
    eventPulseIn = 1'b1;
    tick();
    cnt = (ledGreenOut[1] === 1'b1) ? 1 : 0;
    eventPulseIn = 1'b0;
    tick();
    if (ledGreenOut[1] === 1'b1) cnt++;
    eventPulseIn = 1'b1;
    tick();
    if (ledGreenOut[1] === 1'b1) cnt++;
    eventPulseIn = 1'b0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (ledGreenOut[1] === 1'b1) cnt++;
    end
    chk("retrig_len", cnt, 5);

    // Reset mid-stretch clears the LED at once.
    digitsIn = 16'h1234;
    eventPulseIn = 1'b1;
    tick();
    eventPulseIn = 1'b0;
    chk("pre_rst_led", ledGreenOut[1], 1);
    resetIn = 1'b1;
    #1;
    chk("midrst_led", ledGreenOut, 0);
    chk("midrst_hex0", hex0Out, 7'h7F);
    tick();
    resetIn = 1'b0;
    tick();
    chk("postrst_led", ledGreenOut[1], 0);
    chk("postrst_hex0", hex0Out, 7'h19);

    // Mirrors.
    demoOrRealModeIn = 1'b1;
    statusIn = 4'b1010;
    chk("mirror_pre", ledRedOut, 4'b0000);
    tick();
    chk("mirror_mode1", ledGreenOut[0], 1);
    chk("mirror_red", ledRedOut, 4'b1010);
    demoOrRealModeIn = 1'b0;
    tick();
    chk("mirror_mode0", ledGreenOut[0], 0);
    tick();

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
